// File: rtl/usb_tx_pkg.sv
// Shared types and widths for the USB transmit scheduler.
package usb_tx_pkg;
  typedef enum logic [1:0] {
    NONE   = 2'b00,
    TOKEN  = 2'b01,
    DATA   = 2'b10,
    HSHAKE = 2'b11
  } pkt_t;

  localparam int TOKEN_W  = 19;
  localparam int DATA_W   = 72;
  localparam int HSHAKE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LAUNCH = 2'b01,
    S_WAIT   = 2'b10,
    S_GAP    = 2'b11
  } sched_state_t;
endpackage

// File: rtl/usb_tx_prio_arb.sv
// Fixed-priority one-hot select; bit 0 has the highest priority.
module usb_tx_prio_arb #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  for (genvar i = 0; i < N; i++) begin : g_sel
    if (i == 0) begin : g_top
      assign gnt[i] = req[i];
    end else begin : g_low
      assign gnt[i] = req[i] & ~(|req[i-1:0]);
    end
  end
endmodule

// File: rtl/usb_tx_sched.sv
// Transmit scheduler: arbitrates hs/tok/dat, launches one packet into the
// encoder, waits for tx_done (or watchdog), then holds off for the inter-packet gap.
module usb_tx_sched
  import usb_tx_pkg::*;
#(
  parameter int IPG_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hs_req,
  input  logic [HSHAKE_W-1:0] hs_pid,
  input  logic                tok_req,
  input  logic [TOKEN_W-1:0]  tok_pkt,
  input  logic                dat_req,
  input  logic [DATA_W-1:0]   dat_pkt,
  output logic                hs_gnt,
  output logic                tok_gnt,
  output logic                dat_gnt,
  input  logic                enc_free,
  input  logic                tx_done,
  output logic [1:0]          pkt_type,
  output logic [TOKEN_W-1:0]  token,
  output logic [DATA_W-1:0]   data,
  output logic [HSHAKE_W-1:0] hshake,
  output logic                sent_pkt,
  output logic                cmpl,
  output logic [1:0]          cmpl_src,
  output logic                cmpl_err,
  output logic                busy
);
  localparam logic [7:0]  IPG_L = 8'(IPG_CYCLES);
  localparam logic [15:0] TO_L  = 16'(TIMEOUT_CYCLES);

  sched_state_t        state, state_nxt;
  logic [2:0]          req, win;
  pkt_t                src, src_sel;
  logic [DATA_W-1:0]   pay, pay_sel;
  logic [15:0]         wd_cnt;
  logic [7:0]          gap_cnt;
  logic                launch_ok, done_now;

  logic                hs_gnt_d, tok_gnt_d, dat_gnt_d, sent_d, cmpl_d, err_d;
  logic [1:0]          pkt_type_d, src_d;
  logic [TOKEN_W-1:0]  token_d;
  logic [DATA_W-1:0]   data_d;
  logic [HSHAKE_W-1:0] hshake_d;

  assign req = {dat_req, tok_req, hs_req};

  usb_tx_prio_arb #(.N(3)) u_arb (
    .req (req),
    .gnt (win)
  );

  assign launch_ok = (state == S_IDLE) && enc_free && (|req);
  // tx_done wins over the terminal count, so err is simply !tx_done
  assign done_now  = (state == S_WAIT) && (tx_done || (wd_cnt == TO_L));
  assign busy      = (state != S_IDLE);

  always_comb begin
    src_sel = NONE;
    pay_sel = '0;
    if (win[0]) begin
      src_sel = HSHAKE;
      pay_sel = DATA_W'(hs_pid);
    end else if (win[1]) begin
      src_sel = TOKEN;
      pay_sel = DATA_W'(tok_pkt);
    end else if (win[2]) begin
      src_sel = DATA;
      pay_sel = dat_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (launch_ok) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (done_now) state_nxt = S_GAP;
      S_GAP:    if (gap_cnt >= IPG_L) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src     <= NONE;
      pay     <= '0;
      wd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (launch_ok) begin
        src <= src_sel;
        pay <= pay_sel;
      end
      if (state == S_LAUNCH)                     wd_cnt <= 16'd1;
      else if (state == S_WAIT && wd_cnt != '1)  wd_cnt <= wd_cnt + 16'd1;
      if (done_now)                              gap_cnt <= '0;
      else if (state == S_GAP && gap_cnt != '1)  gap_cnt <= gap_cnt + 8'd1;
    end
  end

  // Outputs are registered: grant lands in LAUNCH, encoder bus the cycle after
  always_comb begin
    hs_gnt_d   = launch_ok & win[0];
    tok_gnt_d  = launch_ok & win[1];
    dat_gnt_d  = launch_ok & win[2];
    pkt_type_d = NONE;
    token_d    = '0;
    data_d     = '0;
    hshake_d   = '0;
    sent_d     = 1'b0;
    cmpl_d     = 1'b0;
    src_d      = NONE;
    err_d      = 1'b0;
    if (state == S_LAUNCH) begin
      pkt_type_d = src;
      unique case (src)
        TOKEN:   token_d  = pay[TOKEN_W-1:0];
        DATA:    data_d   = pay;
        HSHAKE:  hshake_d = pay[HSHAKE_W-1:0];
        default: ;
      endcase
    end
    if (done_now) begin
      sent_d = 1'b1;
      cmpl_d = 1'b1;
      src_d  = src;
      err_d  = ~tx_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_gnt   <= 1'b0;
      tok_gnt  <= 1'b0;
      dat_gnt  <= 1'b0;
      pkt_type <= NONE;
      token    <= '0;
      data     <= '0;
      hshake   <= '0;
      sent_pkt <= 1'b0;
      cmpl     <= 1'b0;
      cmpl_src <= NONE;
      cmpl_err <= 1'b0;
    end else begin
      hs_gnt   <= hs_gnt_d;
      tok_gnt  <= tok_gnt_d;
      dat_gnt  <= dat_gnt_d;
      pkt_type <= pkt_type_d;
      token    <= token_d;
      data     <= data_d;
      hshake   <= hshake_d;
      sent_pkt <= sent_d;
      cmpl     <= cmpl_d;
      cmpl_src <= src_d;
      cmpl_err <= err_d;
    end
  end
endmodule
